// File: rtl/tinyml_cam_pkg.sv
// tinyml_cam_pkg: shared types and constants for the camera frame-capture sequencer.
//   state_e    : capture FSM state encoding
//   XY_W       : width of the scaler in_x/in_y coordinates
//   BEAT_CNT_W : width of the scaler output beat counter
//   exp_beats  : expected scaler output beats for a given input frame size
package tinyml_cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int XY_W       = 11;
    localparam int BEAT_CNT_W = 20;

    function automatic int exp_beats(input int width, input int height);
        return (width / 4) * (height / 2);
    endfunction

endpackage

// File: rtl/tinyml_cam_xy_counter.sv
// tinyml_cam_xy_counter: beat/line position counter for a 2PPC camera frame.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : frame-start strobe, returns the position to (0,0)
//   en         : count one beat this cycle
//   x, y       : current beat index within the line, current line index
//   last       : en on the final beat of the frame
module tinyml_cam_xy_counter
    import tinyml_cam_pkg::*;
#(
    parameter int BPL   = 540,
    parameter int LINES = 1080
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    output logic [XY_W-1:0] x,
    output logic [XY_W-1:0] y,
    output logic            last
);

    localparam logic [XY_W-1:0] X_LAST = XY_W'(BPL - 1);
    localparam logic [XY_W-1:0] Y_LAST = XY_W'(LINES - 1);

    logic [XY_W-1:0] x_q, x_d, y_q, y_d;
    logic            x_end;

    always_comb begin
        x_end = x_q == X_LAST;
        last  = en & x_end & (y_q == Y_LAST);
        x_d   = clr ? '0 : en ? (x_end ? '0 : x_q + 1'b1) : x_q;
        y_d   = clr ? '0 : (en & x_end) ? y_q + 1'b1 : y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/tinyml_cam_scale_frame_ctrl.sv
// tinyml_cam_scale_frame_ctrl: single-frame capture sequencer in front of the 2PPC 2x scaler.
// Arms on cap_start, aligns to the next camera frame start, feeds exactly one frame to the
// scaler with beat coordinates, then checks the scaler output beat count and pulses cap_done.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   cam_vs, cam_valid          : camera vsync level (rising edge = frame start), beat valid
//   cam_r/g/b                  : camera pixel pair per colour
//   cap_start, cap_abort       : capture request / abandon pulses
//   cap_busy, cap_done, cap_err: status (busy level, done pulse, sticky error)
//   scl_rst_n                  : scaler reset, released only while a frame is in flight
//   scl_in_valid, scl_in_x/y   : scaler input strobe and beat coordinates
//   scl_r/g/b                  : scaler pixel pair per colour
//   scl_out_valid, ds_ready    : scaler output strobe, downstream ready
//   ovf_flag                   : sticky, scaler output seen while downstream not ready
//   drop_cnt                   : only with TINYML_CAM_FRAME_CTRL_DROP_CNT_EN, saturating drop count
module tinyml_cam_scale_frame_ctrl
    import tinyml_cam_pkg::*;
#(
    parameter int P_DEPTH         = 8,
    parameter int IN_FRAME_WIDTH  = 1080,
    parameter int IN_FRAME_HEIGHT = 1080
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cam_vs,
    input  logic                 cam_valid,
    input  logic [2*P_DEPTH-1:0] cam_r,
    input  logic [2*P_DEPTH-1:0] cam_g,
    input  logic [2*P_DEPTH-1:0] cam_b,
    input  logic                 cap_start,
    input  logic                 cap_abort,
    output logic                 cap_busy,
    output logic                 cap_done,
    output logic                 cap_err,
    output logic                 scl_rst_n,
    output logic                 scl_in_valid,
    output logic [XY_W-1:0]      scl_in_x,
    output logic [XY_W-1:0]      scl_in_y,
    output logic [2*P_DEPTH-1:0] scl_r,
    output logic [2*P_DEPTH-1:0] scl_g,
    output logic [2*P_DEPTH-1:0] scl_b,
    input  logic                 scl_out_valid,
    input  logic                 ds_ready,
    output logic                 ovf_flag
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int                    BPL = IN_FRAME_WIDTH / 2;
    localparam logic [BEAT_CNT_W-1:0] EXP = BEAT_CNT_W'(exp_beats(IN_FRAME_WIDTH, IN_FRAME_HEIGHT));

    state_e                 state_q, state_d;
    logic                   vs_q;
    logic                   drain_q, drain_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   srst_n_q, srst_n_d;
    logic                   in_valid_q, in_valid_d;
    logic [XY_W-1:0]        in_x_q, in_y_q;
    logic [2*P_DEPTH-1:0]   r_q, g_q, b_q;

    logic                   fs, in_cap, drop, start_acc, last;
    logic [XY_W-1:0]        x, y;

    tinyml_cam_xy_counter #(
        .BPL   (BPL),
        .LINES (IN_FRAME_HEIGHT)
    ) u_xy (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fs),
        .en    (cam_valid & in_cap),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    always_comb begin
        fs        = cam_vs & ~vs_q;
        in_cap    = state_q == ST_CAPTURE;
        drop      = scl_out_valid & ~ds_ready;
        start_acc = (state_q == ST_IDLE) & cap_start & ~cap_abort;
        state_d   = state_q;
        drain_d   = drain_q;
        err_d     = err_q;
        beat_d    = (scl_out_valid && (state_q == ST_CAPTURE || state_q == ST_DRAIN)) ? beat_q + 1'b1 : beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_ARMED;
                    beat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (fs) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // The final beat takes priority over a coincident frame start.
                if (last) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else if (fs) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Two cycles cover the scaler latency; the count includes this cycle's output beat.
                if (drain_q) begin
                    state_d = ST_DONE;
                    err_d   = err_q | (beat_d != EXP);
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cap_abort) state_d = ST_IDLE;
        ovf_d      = (start_acc ? 1'b0 : ovf_q) | drop;
        busy_d     = state_d inside {ST_ARMED, ST_CAPTURE, ST_DRAIN};
        done_d     = state_d == ST_DONE;
        srst_n_d   = state_d inside {ST_CAPTURE, ST_DRAIN};
        // An abort also suppresses the beat presented alongside it.
        in_valid_d = cam_valid & in_cap & ~cap_abort;
    end

`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = start_acc ? 16'd0 : drop_cnt_q;
        drop_cnt_d = (drop && drop_cnt_d != 16'hFFFF) ? drop_cnt_d + 16'd1 : drop_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b0;
            drain_q    <= 1'b0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            srst_n_q   <= 1'b0;
            in_valid_q <= 1'b0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= cam_vs;
            drain_q    <= drain_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            srst_n_q   <= srst_n_d;
            in_valid_q <= in_valid_d;
            in_x_q     <= x;
            in_y_q     <= y;
            r_q        <= cam_r;
            g_q        <= cam_g;
            b_q        <= cam_b;
        end
    end

    assign cap_busy     = busy_q;
    assign cap_done     = done_q;
    assign cap_err      = err_q;
    assign scl_rst_n    = srst_n_q;
    assign scl_in_valid = in_valid_q;
    assign scl_in_x     = in_x_q;
    assign scl_in_y     = in_y_q;
    assign scl_r        = r_q;
    assign scl_g        = g_q;
    assign scl_b        = b_q;
    assign ovf_flag     = ovf_q;

endmodule

// File: tb/tb_tinyml_cam_scale_frame_ctrl.sv
// tb_tinyml_cam_scale_frame_ctrl: randomized self-checking bench for the frame-capture sequencer.
module tb_tinyml_cam_scale_frame_ctrl;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int BPL = W / 2;
    localparam int NB  = BPL * H;
    localparam int EXP = (W / 4) * (H / 2);

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        int          c;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cam_vs = 1'b0, cam_valid = 1'b0, cap_start = 1'b0, cap_abort = 1'b0;
    logic [15:0] cam_r = '0, cam_g = '0, cam_b = '0;
    logic        scl_out_valid = 1'b0, ds_ready = 1'b1;
    logic        cap_busy, cap_done, cap_err, scl_rst_n, scl_in_valid, ovf_flag;
    logic [10:0] scl_in_x, scl_in_y;
    logic [15:0] scl_r, scl_g, scl_b;
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int    errors = 0, checks = 0, cyc = 0;
    int    exp_done_cyc = -1, done_cnt = 0, last_cyc = 0;
    int    outs = 0, drops_left = 0, skip_left = 0;
    beat_t expq[$];
    beat_t eb;
    logic  ev, frame_first = 1'b0;
    logic [21:0] first_xy, last_xy;

    tinyml_cam_scale_frame_ctrl #(
        .P_DEPTH         (8),
        .IN_FRAME_WIDTH  (W),
        .IN_FRAME_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cam_vs        (cam_vs),
        .cam_valid     (cam_valid),
        .cam_r         (cam_r),
        .cam_g         (cam_g),
        .cam_b         (cam_b),
        .cap_start     (cap_start),
        .cap_abort     (cap_abort),
        .cap_busy      (cap_busy),
        .cap_done      (cap_done),
        .cap_err       (cap_err),
        .scl_rst_n     (scl_rst_n),
        .scl_in_valid  (scl_in_valid),
        .scl_in_x      (scl_in_x),
        .scl_in_y      (scl_in_y),
        .scl_r         (scl_r),
        .scl_g         (scl_g),
        .scl_b         (scl_b),
        .scl_out_valid (scl_out_valid),
        .ds_ready      (ds_ready),
        .ovf_flag      (ovf_flag)
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cam_r = 16'($urandom);
        cam_g = 16'($urandom);
        cam_b = 16'($urandom);
    endtask

    // Scaler stand-in: one output beat per pair of input beats on every other line.
    always @(negedge clk) begin
        scl_out_valid = scl_in_valid & ~scl_in_x[0] & ~scl_in_y[0];
        if (scl_out_valid && skip_left > 0) begin
            scl_out_valid = 1'b0;
            skip_left--;
        end
        ds_ready = 1'b1;
        if (scl_out_valid) begin
            outs++;
            if (drops_left > 0) begin
                ds_ready = 1'b0;
                drops_left--;
            end
        end
    end

    // Cycle-accurate compare of the scaler input stream and the done pulse against the model.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].c < cyc) void'(expq.pop_front());
        ev = expq.size() > 0 && expq[0].c == cyc;
        chk("scl_in_valid", scl_in_valid, ev);
        if (ev && scl_in_valid) begin
            eb = expq.pop_front();
            chk("scl_in_beat", {scl_in_x, scl_in_y, scl_r, scl_g, scl_b}, {eb.x, eb.y, eb.r, eb.g, eb.b});
            if (frame_first) first_xy = {scl_in_x, scl_in_y};
            frame_first = 1'b0;
            last_xy = {scl_in_x, scl_in_y};
        end
        chk("cap_done", cap_done, cyc == exp_done_cyc);
        if (cap_done) done_cnt++;
    end

    task automatic beat(input bit cap, input int idx, input bit gaps);
        beat_t b;
        cam_valid = 1'b0;
        if (gaps) for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) step();
        cam_valid = 1'b1;
        if (cap) begin
            b.x = 11'(idx % BPL);
            b.y = 11'(idx / BPL);
            b.r = cam_r;
            b.g = cam_g;
            b.b = cam_b;
            b.c = cyc + 1;
            expq.push_back(b);
            last_cyc = cyc;
        end
        step();
        cam_valid = 1'b0;
    endtask

    task automatic capture_frame(input bit gaps, input int drops, input int skips, input int start_at, input bit same_fs);
        int d0;
        drops_left  = drops;
        skip_left   = skips;
        outs        = 0;
        frame_first = 1'b1;
        cap_start = 1'b1;
        cam_vs    = same_fs;
        step();
        cap_start = 1'b0;
        cam_vs    = 1'b0;
        chk("armed_busy", cap_busy, 1'b1);
        chk("armed_scl_rst_n", scl_rst_n, 1'b0);
        chk("start_clears_err", cap_err, 1'b0);
        chk("start_clears_ovf", ovf_flag, 1'b0);
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
        chk("start_clears_drop_cnt", drop_cnt, 16'd0);
`endif
        if (same_fs) begin
            for (int i = 0; i < 3; i++) beat(1'b0, i, 1'b0);
            chk("armed_waits_next_fs", scl_rst_n, 1'b0);
        end
        cam_vs = 1'b1;
        step();
        cam_vs = 1'b0;
        chk("capture_scl_rst_n", scl_rst_n, 1'b1);
        for (int i = 0; i < NB; i++) begin
            cap_start = (i == start_at);
            beat(1'b1, i, gaps);
            cap_start = 1'b0;
        end
        d0 = done_cnt;
        exp_done_cyc = last_cyc + 3;
        for (int i = 0; i < 12 && done_cnt == d0; i++) step();
        exp_done_cyc = -1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("out_beats", outs, EXP - skips);
        chk("cap_err_count", cap_err, (EXP - skips) != EXP);
        chk("ovf_flag", ovf_flag, drops > 0);
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, 16'(drops));
`endif
        chk("idle_busy", cap_busy, 1'b0);
        chk("idle_scl_rst_n", scl_rst_n, 1'b0);
        chk("first_xy", first_xy, {11'd0, 11'd0});
        chk("last_xy", last_xy, {11'd7, 11'd3});
        chk("queue_drained", expq.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_busy", cap_busy, 1'b0);
        chk("rst_done", cap_done, 1'b0);
        chk("rst_err", cap_err, 1'b0);
        chk("rst_scl_rst_n", scl_rst_n, 1'b0);
        chk("rst_in_valid", scl_in_valid, 1'b0);
        chk("rst_xy", {scl_in_x, scl_in_y}, 22'd0);
        chk("rst_ovf", ovf_flag, 1'b0);
        rst_n = 1'b1;
        step();

        capture_frame(1'b0, 0, 0, -1, 1'b1);
        capture_frame(1'b1, 0, 0, -1, 1'b0);

        // Short frame: a new frame start arrives after 20 beats.
        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        cam_vs = 1'b1;
        step();
        cam_vs = 1'b0;
        for (int i = 0; i < 20; i++) beat(1'b1, i, 1'b1);
        d0 = done_cnt;
        cam_vs = 1'b1;
        exp_done_cyc = cyc + 1;
        step();
        cam_vs = 1'b0;
        chk("short_err", cap_err, 1'b1);
        chk("short_scl_rst_n", scl_rst_n, 1'b0);
        chk("short_busy", cap_busy, 1'b0);
        step();
        exp_done_cyc = -1;
        chk("short_done_pulses", done_cnt - d0, 1);
        step();

        // Abort on beat 10.
        cap_start = 1'b1;
        step();
        cap_start = 1'b0;
        cam_vs = 1'b1;
        step();
        cam_vs = 1'b0;
        for (int i = 0; i < 10; i++) beat(1'b1, i, 1'b0);
        d0 = done_cnt;
        cap_abort = 1'b1;
        cam_valid = 1'b1;
        step();
        cap_abort = 1'b0;
        cam_valid = 1'b0;
        chk("abort_busy", cap_busy, 1'b0);
        chk("abort_scl_rst_n", scl_rst_n, 1'b0);
        for (int i = 0; i < 8; i++) beat(1'b0, i, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue", expq.size(), 0);

        // Backpressure on three output beats, plus an ignored cap_start mid-capture.
        capture_frame(1'b0, 3, 0, 16, 1'b0);

        // cap_start together with cap_abort in IDLE is ignored and clears nothing.
        cap_start = 1'b1;
        cap_abort = 1'b1;
        step();
        cap_start = 1'b0;
        cap_abort = 1'b0;
        chk("start_abort_busy", cap_busy, 1'b0);
        chk("start_abort_keeps_ovf", ovf_flag, 1'b1);
`ifdef TINYML_CAM_FRAME_CTRL_DROP_CNT_EN
        chk("start_abort_keeps_drop_cnt", drop_cnt, 16'd3);
`endif
        step();
        chk("start_abort_still_idle", cap_busy, 1'b0);

        // Missing scaler output beat must flag a count error.
        capture_frame(1'b1, 0, 1, -1, 1'b0);

        for (int f = 0; f < 5; f++)
            capture_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3) == 0 ? 1 : 0,
                          $urandom_range(0, 40), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
